// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle control sequencer for a five-stage datapath
//   (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, plus a terminal HALT state).
// Latency: 5 falling edges per instruction, plus 1 per stalled MEMORY edge.
// Backpressure: mem_access && !mem_ready holds MEMORY. MEM_WAIT_MAX consecutive
//   stalls halt the sequencer with mem_timeout set.
// Optional: define STAGE_SEQ_SINGLE_STEP_EN to add a 'step' input that gates
//   FETCH->DECODE.
// Ports:
//   clock, reset (async, active-low), end_program, branch, zero, branch_offset,
//   mem_access, mem_ready, [step] -> pc, stage, stage_en, halted, mem_timeout,
//   instr_count.
// All state updates on the falling edge of clock.
module stage_sequencer #(
   parameter int PC_WIDTH     = 4,
   parameter int PROG_LEN     = 11,
   parameter int RESET_PC     = 0,
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                end_program,
   input  logic                branch,
   input  logic                zero,
   input  logic [PC_WIDTH-1:0] branch_offset,
   input  logic                mem_access,
   input  logic                mem_ready,
`ifdef STAGE_SEQ_SINGLE_STEP_EN
   input  logic                step,
`endif
   output logic [PC_WIDTH-1:0] pc,
   output logic [2:0]          stage,
   output logic [4:0]          stage_en,
   output logic                halted,
   output logic                mem_timeout,
   output logic [15:0]         instr_count
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } stage_e;

   // Two guard bits so pc + 1 + PROG_LEN cannot wrap before the modulo.
   localparam int             AW    = PC_WIDTH + 2;
   localparam logic [AW-1:0]  LEN_W = AW'(PROG_LEN);
   localparam logic [AW-1:0]  ONE_W = AW'(1);
   localparam logic [7:0]     WMAX  = 8'(MEM_WAIT_MAX);

   stage_e              stage_q, stage_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [7:0]          wait_q, wait_d;
   logic                tmo_q, tmo_d;

   logic                fetch_go;
   logic [AW-1:0]       pc_ext, off_mod, pc_seq, pc_tgt;

`ifdef STAGE_SEQ_SINGLE_STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   // Next-PC candidates; only committed on the WRITEBACK edge.
   always_comb begin
      pc_ext  = AW'(pc_q);
      off_mod = AW'(branch_offset) % LEN_W;
      pc_seq  = (pc_ext + ONE_W) % LEN_W;
      pc_tgt  = (pc_ext + ONE_W + LEN_W - off_mod) % LEN_W;
   end

   always_comb begin
      stage_d = stage_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      tmo_d   = tmo_q;
      unique case (stage_q)
         ST_FETCH: begin
            if (fetch_go) stage_d = ST_DECODE;
         end
         ST_DECODE: begin
            stage_d = end_program ? ST_HALT : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            stage_d = ST_MEMORY;
         end
         ST_MEMORY: begin
            if (!mem_access || mem_ready) begin
               // Leaving MEMORY ends the stall run, so the next one starts from zero.
               stage_d = ST_WRITEBACK;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 8'd1;
               if (wait_q + 8'd1 == WMAX) begin
                  stage_d = ST_HALT;
                  tmo_d   = 1'b1;
               end
            end
         end
         ST_WRITEBACK: begin
            stage_d = ST_FETCH;
            cnt_d   = cnt_q + 16'd1;
            pc_d    = (branch && !zero) ? PC_WIDTH'(pc_tgt) : PC_WIDTH'(pc_seq);
         end
         ST_HALT: begin
            stage_d = ST_HALT;
         end
         default: begin
            stage_d = ST_HALT;
         end
      endcase
   end

   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         stage_q <= ST_FETCH;
         pc_q    <= PC_WIDTH'(RESET_PC);
         cnt_q   <= '0;
         wait_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         stage_q <= stage_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      stage_en = 5'b00000;
      case (stage_q)
         ST_FETCH:     stage_en = 5'b00001;
         ST_DECODE:    stage_en = 5'b00010;
         ST_EXECUTE:   stage_en = 5'b00100;
         ST_MEMORY:    stage_en = 5'b01000;
         ST_WRITEBACK: stage_en = 5'b10000;
         default:      stage_en = 5'b00000;
      endcase
   end

   assign stage       = stage_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign halted      = (stage_q == ST_HALT);
   assign mem_timeout = tmo_q;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;
   localparam int PC_WIDTH     = 4;
   localparam int PROG_LEN     = 11;
   localparam int MEM_WAIT_MAX = 15;

   logic                clock = 1'b1;
   logic                reset = 1'b0;
   logic                end_program = 1'b0, branch = 1'b0, zero = 1'b0;
   logic [PC_WIDTH-1:0] branch_offset = '0;
   logic                mem_access = 1'b0, mem_ready = 1'b0;
   logic                step = 1'b1;
   logic [PC_WIDTH-1:0] pc;
   logic [2:0]          stage;
   logic [4:0]          stage_en;
   logic                halted, mem_timeout;
   logic [15:0]         instr_count;

   int n_tests = 0;
   int n_fail  = 0;

   stage_sequencer #(.PC_WIDTH(PC_WIDTH), .PROG_LEN(PROG_LEN), .RESET_PC(0),
                     .MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
      .clock(clock), .reset(reset), .end_program(end_program), .branch(branch),
      .zero(zero), .branch_offset(branch_offset), .mem_access(mem_access),
      .mem_ready(mem_ready),
`ifdef STAGE_SEQ_SINGLE_STEP_EN
      .step(step),
`endif
      .pc(pc), .stage(stage), .stage_en(stage_en), .halted(halted),
      .mem_timeout(mem_timeout), .instr_count(instr_count));

   always #5 clock = ~clock;

   // Behavioural model: stage number, pc, retired count, current stall run.
   int m_stage = 0, m_pc = 0, m_cnt = 0, m_stall = 0;
   bit m_to = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stage = 0; m_pc = 0; m_cnt = 0; m_stall = 0; m_to = 0;
   endtask

   task automatic model_step();
      bit go;
      go = 1'b1;
`ifdef STAGE_SEQ_SINGLE_STEP_EN
      go = step;
`endif
      if (m_stage == 0) begin
         if (go) m_stage = 1;
      end else if (m_stage == 1) begin
         m_stage = end_program ? 5 : 2;
      end else if (m_stage == 2) begin
         m_stage = 3;
      end else if (m_stage == 3) begin
         if (!mem_access || mem_ready) begin
            m_stall = 0; m_stage = 4;
         end else begin
            m_stall++;
            if (m_stall == MEM_WAIT_MAX) begin m_stage = 5; m_to = 1; end
         end
      end else if (m_stage == 4) begin
         if (branch && !zero)
            m_pc = (m_pc + 1 + PROG_LEN - (int'(branch_offset) % PROG_LEN)) % PROG_LEN;
         else
            m_pc = (m_pc + 1) % PROG_LEN;
         m_cnt = (m_cnt + 1) % 65536;
         m_stage = 0;
      end
   endtask

   always @(negedge clock) if (reset) model_step();

   // Continuous compare, away from the active (falling) edge.
   always @(posedge clock) begin
      if (reset) begin
         check("stage", int'(stage), m_stage);
         check("stage_en", int'(stage_en), (m_stage < 5) ? (1 << m_stage) : 0);
         check("pc", int'(pc), m_pc);
         check("instr_count", int'(instr_count), m_cnt);
         check("halted", int'(halted), (m_stage == 5) ? 1 : 0);
         check("mem_timeout", int'(mem_timeout), int'(m_to));
      end
   end

   // Drive inputs just after a falling edge; they are sampled at the next one.
   task automatic edge_in(input bit ep, input bit br, input bit z,
                          input logic [3:0] off, input bit ma, input bit mr);
      end_program = ep; branch = br; zero = z; branch_offset = off;
      mem_access = ma; mem_ready = mr;
      @(negedge clock); #1;
   endtask

   task automatic assert_reset();
      @(posedge clock); #2;
      reset = 1'b0;
      model_reset();
      end_program = 0; branch = 0; zero = 0; branch_offset = '0;
      mem_access = 0; mem_ready = 0;
   endtask

   task automatic release_reset();
      @(negedge clock); @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic full_reset();
      assert_reset();
      release_reset();
   endtask

   task automatic run_instr(input bit br, input bit z, input logic [3:0] off,
                            input bit ma, input int stalls);
      edge_in(0, br, z, off, ma, 0);            // FETCH
      edge_in(0, br, z, off, ma, 0);            // DECODE
      edge_in(0, br, z, off, ma, 0);            // EXECUTE
      for (int i = 0; i < stalls; i++) edge_in(0, br, z, off, ma, 0);
      edge_in(0, br, z, off, ma, 1);            // MEMORY completes
      edge_in(0, br, z, off, ma, 0);            // WRITEBACK
   endtask

   initial begin
      int mode;
      int halt_wait;
      // 1: reset state and basic sequence
      full_reset();
      check("rst_stage", int'(stage), 0);
      check("rst_en", int'(stage_en), 1);
      check("rst_pc", int'(pc), 0);
      check("rst_cnt", int'(instr_count), 0);
      for (int i = 1; i <= 4; i++) begin
         edge_in(0, 0, 0, 0, 0, 0);
         check("seq_stage", int'(stage), i);
      end
      edge_in(0, 0, 0, 0, 0, 0);
      check("seq_pc", int'(pc), 1);
      check("seq_cnt", int'(instr_count), 1);
      check("seq_back_fetch", int'(stage), 0);

      // 2: wrap at PROG_LEN
      for (int i = 0; i < 9; i++) run_instr(0, 0, 0, 0, 0);
      check("pc_10", int'(pc), 10);
      run_instr(0, 0, 0, 0, 0);
      check("pc_wrap", int'(pc), 0);
      check("cnt_11", int'(instr_count), 11);

      // 3: branches from pc=2
      full_reset();
      run_instr(0, 0, 0, 0, 0); run_instr(0, 0, 0, 0, 0);
      run_instr(1, 0, 4'd3, 0, 0);
      check("br_off3", int'(pc), 0);
      full_reset();
      run_instr(0, 0, 0, 0, 0); run_instr(0, 0, 0, 0, 0);
      run_instr(1, 0, 4'd5, 0, 0);
      check("br_off5", int'(pc), 9);
      full_reset();
      run_instr(0, 0, 0, 0, 0); run_instr(0, 0, 0, 0, 0);
      run_instr(1, 1, 4'd5, 0, 0);
      check("br_zero", int'(pc), 3);
      full_reset();
      run_instr(0, 0, 0, 0, 0); run_instr(0, 0, 0, 0, 0);
      run_instr(1, 0, 4'd13, 0, 0);             // 13 mod 11 = 2 -> pc 1
      check("br_off13", int'(pc), 1);

      // 4a: three stalls then ready
      full_reset();
      edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         edge_in(0, 0, 0, 0, 1, 0);
         check("stall_hold", int'(stage), 3);
      end
      edge_in(0, 0, 0, 0, 1, 1);
      check("stall_done", int'(stage), 4);

      // 4b: timeout
      full_reset();
      edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < MEM_WAIT_MAX - 1; i++) edge_in(0, 0, 0, 0, 1, 0);
      check("tmo_pre_stage", int'(stage), 3);
      check("tmo_pre_flag", int'(mem_timeout), 0);
      edge_in(0, 0, 0, 0, 1, 0);
      check("tmo_stage", int'(stage), 5);
      check("tmo_halted", int'(halted), 1);
      check("tmo_flag", int'(mem_timeout), 1);
      check("tmo_en", int'(stage_en), 0);

      // 5: end_program at DECODE
      full_reset();
      run_instr(0, 0, 0, 0, 0);
      edge_in(0, 0, 0, 0, 0, 0);
      edge_in(1, 0, 0, 0, 0, 0);
      check("end_stage", int'(stage), 5);
      check("end_halted", int'(halted), 1);
      check("end_cnt", int'(instr_count), 1);
      check("end_to", int'(mem_timeout), 0);
      for (int i = 0; i < 10; i++)
         edge_in($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      check("halt_stage", int'(stage), 5);
      check("halt_pc", int'(pc), 1);
      check("halt_cnt", int'(instr_count), 1);

      // 6: reset mid-stall, between edges
      full_reset();
      run_instr(0, 0, 0, 0, 0);
      edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0);
      edge_in(0, 0, 0, 0, 1, 0); edge_in(0, 0, 0, 0, 1, 0);
      assert_reset();
      #1;
      check("arst_pc", int'(pc), 0);
      check("arst_stage", int'(stage), 0);
      check("arst_en", int'(stage_en), 1);
      check("arst_cnt", int'(instr_count), 0);
      check("arst_to", int'(mem_timeout), 0);
      release_reset();
      run_instr(0, 0, 0, 1, 2);
      check("arst_resume_pc", int'(pc), 1);
      check("arst_resume_cnt", int'(instr_count), 1);

      // Randomized run, compared every cycle against the model.
      full_reset();
      mode = $urandom_range(0, 2);
      halt_wait = 0;
      for (int i = 0; i < 4000; i++) begin
         bit mr;
         if (mode == 0) mr = ($urandom_range(0, 1) == 1);
         else if (mode == 1) mr = ($urandom_range(0, 19) == 0);
         else mr = ($urandom_range(0, 3) != 0);
`ifdef STAGE_SEQ_SINGLE_STEP_EN
         step = ($urandom_range(0, 2) != 0);
`endif
         edge_in($urandom_range(0, 59) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                 4'($urandom), $urandom_range(0, 3) != 0, mr);
         if (m_stage == 5) halt_wait++;
         if (halt_wait > 4 || $urandom_range(0, 499) == 0) begin
            assert_reset();
            #1;
            check("rnd_arst_stage", int'(stage), 0);
            check("rnd_arst_pc", int'(pc), 0);
            release_reset();
            mode = $urandom_range(0, 2);
            halt_wait = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
